// File: rtl/jtopl_eg_seq.sv
// Steps a slot counter over all operator slots and holds each slot's envelope state, attenuation and last key level.
// Read path is combinational from slot; write-back lands at the edge ending the slot. No backpressure; cen gates every register.
module jtopl_eg_seq #(
   parameter int SLOTS = 18,
   parameter int EGW   = 10,
   parameter int CNTW  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic            keyon,
   input  logic [2:0]      state_next,
   input  logic [EGW-1:0]  eg_next,
   output logic [4:0]      slot,
   output logic            zero,
   output logic [CNTW-1:0] eg_cnt,
   output logic            keyon_now,
   output logic            keyoff_now,
   output logic [2:0]      state_cur,
   output logic [EGW-1:0]  eg_cur
);

   localparam logic [2:0] ST_RELEASE = 3'b100;
   localparam logic [4:0] LAST_SLOT  = 5'(SLOTS - 1);

   typedef struct packed {
      logic [2:0]     state;
      logic [EGW-1:0] eg;
      logic           key_last;
   } entry_t;

   entry_t          entry [SLOTS];
   entry_t          cur;
   logic [CNTW-1:0] cnt_inc;

   assign cur        = entry[slot];
   assign state_cur  = cur.state;
   assign eg_cur     = cur.eg;
   assign keyon_now  = keyon & ~cur.key_last;
   assign keyoff_now = ~keyon & cur.key_last;

   // Zero means "no tick" to the step logic, so the wrap lands on 1.
   always_comb begin
      cnt_inc = eg_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      if (cnt_inc == '0)
         cnt_inc = {{(CNTW-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot   <= 5'd0;
         zero   <= 1'b1;
         eg_cnt <= '0;
         for (int i = 0; i < SLOTS; i++)
            entry[i] <= '{state: ST_RELEASE, eg: '1, key_last: 1'b0};
      end else if (cen) begin
         entry[slot] <= '{state: state_next, eg: eg_next, key_last: keyon};
         if (slot == LAST_SLOT) begin
            slot   <= 5'd0;
            zero   <= 1'b1;
            eg_cnt <= cnt_inc;
         end else begin
            slot   <= slot + 5'd1;
            zero   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtopl_eg_seq.sv
// Scoreboard bench for jtopl_eg_seq: a reference model predicts every output each cycle.
module tb_jtopl_eg_seq;
   localparam int SLOTS = 18;
   localparam int EGW   = 10;
   localparam int CNTW  = 5;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic            clk = 1'b0;
   logic            rst_n, cen, keyon;
   logic [2:0]      state_next;
   logic [EGW-1:0]  eg_next;
   logic [4:0]      slot;
   logic            zero, keyon_now, keyoff_now;
   logic [CNTW-1:0] eg_cnt;
   logic [2:0]      state_cur;
   logic [EGW-1:0]  eg_cur;

   jtopl_eg_seq #(.SLOTS(SLOTS), .EGW(EGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .keyon(keyon),
      .state_next(state_next), .eg_next(eg_next),
      .slot(slot), .zero(zero), .eg_cnt(eg_cnt),
      .keyon_now(keyon_now), .keyoff_now(keyoff_now),
      .state_cur(state_cur), .eg_cur(eg_cur)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]      slot;
      logic            zero;
      logic [CNTW-1:0] cnt;
      logic            kon, koff;
      logic [2:0]      st;
      logic [EGW-1:0]  eg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model
   bit              m_valid = 1'b0;
   int              m_slot;
   logic [CNTW-1:0] m_cnt;
   logic [2:0]      m_st  [SLOTS];
   logic [EGW-1:0]  m_eg  [SLOTS];
   logic            m_key [SLOTS];
   bit              saw_wrap = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s slot=%0d got=%h exp=%h", tag, m_slot, got, exp);
      end
   endtask

   task automatic step(input bit rst_i, input bit cen_i, input bit key_i,
                       input logic [2:0] sn, input logic [EGW-1:0] en);
      exp_t e, o;
      rst_n = rst_i; cen = cen_i; keyon = key_i; state_next = sn; eg_next = en;
      if (m_valid) begin
         e.slot = 5'(m_slot);
         e.zero = (m_slot == 0);
         e.cnt  = m_cnt;
         e.kon  = key_i & ~m_key[m_slot];
         e.koff = ~key_i & m_key[m_slot];
         e.st   = m_st[m_slot];
         e.eg   = m_eg[m_slot];
         exp_q.push_back(e);
      end
      @(negedge clk);
      if (exp_q.size() != 0) begin
         o = exp_q.pop_front();
         chk("slot",       32'(slot),       32'(o.slot));
         chk("zero",       32'(zero),       32'(o.zero));
         chk("eg_cnt",     32'(eg_cnt),     32'(o.cnt));
         chk("keyon_now",  32'(keyon_now),  32'(o.kon));
         chk("keyoff_now", 32'(keyoff_now), 32'(o.koff));
         chk("state_cur",  32'(state_cur),  32'(o.st));
         chk("eg_cur",     32'(eg_cur),     32'(o.eg));
      end
      @(posedge clk);
      if (!rst_i) begin
         m_valid = 1'b1;
         m_slot  = 0;
         m_cnt   = '0;
         for (int i = 0; i < SLOTS; i++) begin
            m_st[i] = 3'b100; m_eg[i] = 10'h3FF; m_key[i] = 1'b0;
         end
      end else if (cen_i && m_valid) begin
         m_st[m_slot]  = sn;
         m_eg[m_slot]  = en;
         m_key[m_slot] = key_i;
         if (m_slot == SLOTS - 1) begin
            if (m_cnt == CNT_MAX) begin
               m_cnt = 1;
               saw_wrap = 1'b1;
            end else begin
               m_cnt = m_cnt + 1'b1;
            end
            m_slot = 0;
         end else begin
            m_slot = m_slot + 1;
         end
      end
      #1;
   endtask

   function automatic logic [2:0] rnd_state();
      int k = $urandom_range(0, 2);
      return 3'b001 << k;
   endfunction

   initial begin
      rst_n = 1'b0; cen = 1'b0; keyon = 1'b0; state_next = 3'b100; eg_next = '1;
      @(posedge clk); #1;

      // reset held with cen toggling
      for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2), 1'b0, 3'b100, 10'h3FF);

      // three full sweeps: reset contents visible, counter ticks per sweep
      for (int i = 0; i < 3 * SLOTS; i++) step(1'b1, 1'b1, 1'b0, 3'b100, 10'h3FF);

      // key on slot 5 for two sweeps, then released
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < SLOTS; i++)
            step(1'b1, 1'b1, (s < 2) && (m_slot == 5), 3'b100, 10'h3FF);

      // single write to slot 7, then a sweep to read it back
      for (int i = 0; i < SLOTS; i++)
         if (m_slot == 7) step(1'b1, 1'b1, 1'b0, 3'b001, 10'h155);
         else             step(1'b1, 1'b1, 1'b0, 3'b100, 10'h3FF);
      for (int i = 0; i < SLOTS; i++) step(1'b1, 1'b1, 1'b0, 3'b100, 10'h3FF);

      // cen on every 4th cycle with random data
      for (int i = 0; i < 8 * SLOTS; i++)
         step(1'b1, (i % 4) == 0, 1'($urandom_range(0, 1)), rnd_state(), EGW'($urandom));

      // run through the counter wrap and one more sweep
      for (int i = 0; i < ((1 << CNTW) + 2) * SLOTS; i++)
         step(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd_state(), EGW'($urandom));
      chk("wrap_seen", 32'(saw_wrap), 32'd1);

      // reset in the middle of a sweep
      for (int i = 0; i < SLOTS && m_slot != 11; i++)
         step(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd_state(), EGW'($urandom));
      chk("pre_rst_slot", 32'(slot), 32'd11);
      step(1'b0, 1'b1, 1'b1, 3'b001, 10'h000);
      for (int i = 0; i < SLOTS + 2; i++) step(1'b1, 1'b1, 1'b0, 3'b100, 10'h3FF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
